// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path: FSM state encoding and
//   the oversampling constants used to locate mid-bit sample points.
//   No ports.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // The start bit is sampled half a bit after the falling edge; every later
  // bit is sampled a full bit after the previous sample point.
  localparam logic [3:0] MID_START = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] MID_BIT   = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchroniser for the asynchronous serial line. Both flops reset
//   to 1 so that the line reads as idle while reset is applied.
// Ports
//   clk  in   system clock
//   rst  in   asynchronous reset, active-high
//   d    in   asynchronous input
//   q    out  synchronised output
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   UART receiver driven by a 16x baud strobe. Detects the start edge,
//   samples each bit at mid-bit, deserialises LSB first, checks optional
//   parity and the stop bit, and offers each frame on a valid/ready port.
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   baud_tick_16x  in   one-clk strobe at 16x baud rate
//   rx             in   serial input, asynchronous, idle high
//   rx_data        out  received word, LSB = first bit on the line
//   rx_valid       out  rx_data and error flags are valid
//   rx_ready       in   consumer accepts the word when rx_valid=1
//   frame_err      out  stop bit sampled 0 (qualified by rx_valid)
//   parity_err     out  parity mismatch (qualified by rx_valid)
//   overrun_err    out  sticky: a frame was dropped while rx_valid was held
//   busy           out  FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for rx_s low (checked every clk)
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling DATA_BITS data bits at mid-bit
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then completing the frame
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam bit         PAR_EN   = (PARITY_EN != 0);
  localparam bit         PAR_ODD  = (PARITY_ODD != 0);

  rx_state_t            state, state_n;
  logic [3:0]           tick_cnt, tick_cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rx_s;
  logic                 shift_en, par_cap, complete;
  logic                 parity_err_n;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_en   = 1'b0;
    par_cap    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end
      START: begin
        if (baud_tick_16x) begin
          if (tick_cnt == MID_START) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n    = DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (baud_tick_16x) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == MID_BIT) begin
            shift_en  = 1'b1;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state_n = PAR_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (baud_tick_16x) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == MID_BIT) begin
            par_cap = 1'b1;
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (baud_tick_16x) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == MID_BIT) begin
            complete = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Right shift: after DATA_BITS samples the first bit received sits in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (shift_en) shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
      if (par_cap)  par_bit <= rx_s;
    end
  end

  assign parity_err_n = PAR_EN && ((^{shreg, par_bit}) != PAR_ODD);

  // A completion coinciding with an accept replaces the word without overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid    <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= ~rx_s;
          parity_err <= parity_err_n;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled
//   Directed bench for uart_rx_oversampled: one 8N1 instance and one 8E1
//   instance. Frames are driven at 160 clk per bit with a tick every 10 clk;
//   expected words are queued when sent and compared on each handshake.
module tb_uart_rx_oversampled;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic ready0 = 1'b1, ready1 = 1'b1;
  logic [7:0] data0, data1;
  logic valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

  always #5 clk = ~clk;

  uart_rx_oversampled #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .baud_tick_16x(tick), .rx(rx0),
    .rx_data(data0), .rx_valid(valid0), .rx_ready(ready0),
    .frame_err(fe0), .parity_err(pe0), .overrun_err(ov0), .busy(busy0)
  );

  uart_rx_oversampled #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
    .clk(clk), .rst(rst), .baud_tick_16x(tick), .rx(rx1),
    .rx_data(data1), .rx_valid(valid1), .rx_ready(ready1),
    .frame_err(fe1), .parity_err(pe1), .overrun_err(ov1), .busy(busy1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;
  int vcyc0 = 0;
  int busy_cyc0 = 0;
  int hs0 = 0;
  int hs1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (c == 9);
      c = (c == 9) ? 0 : c + 1;
    end
  end

  task automatic drive_bit(input int sel, input logic v, input int clks);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
    repeat (clks) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                            input logic par, input logic stop, input int gap_bits);
    drive_bit(sel, 1'b0, 160);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], 160);
    if (par_en) drive_bit(sel, par, 160);
    if (stop) begin
      drive_bit(sel, 1'b1, 160);
    end else begin
      drive_bit(sel, 1'b0, 100);
      drive_bit(sel, 1'b1, 60);
    end
    drive_bit(sel, 1'b1, 160 * gap_bits);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid0) vcyc0++;
      if (busy0) busy_cyc0++;
      if (valid0 && ready0) begin
        hs0++;
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0_unexpected_word: got 0x%0h required no word", data0);
        end else begin
          e = q0.pop_front();
          chk("dut0_rx_data", {24'd0, data0}, {24'd0, e.d});
          chk("dut0_frame_err", {31'd0, fe0}, {31'd0, e.fe});
          chk("dut0_parity_err", {31'd0, pe0}, {31'd0, e.pe});
        end
      end
      if (valid1 && ready1) begin
        hs1++;
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1_unexpected_word: got 0x%0h required no word", data1);
        end else begin
          e = q1.pop_front();
          chk("dut1_rx_data", {24'd0, data1}, {24'd0, e.d});
          chk("dut1_frame_err", {31'd0, fe1}, {31'd0, e.fe});
          chk("dut1_parity_err", {31'd0, pe1}, {31'd0, e.pe});
        end
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_before;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", {24'd0, data0}, 32'd0);
    chk("reset_rx_valid", {31'd0, valid0}, 32'd0);
    chk("reset_frame_err", {31'd0, fe0}, 32'd0);
    chk("reset_parity_err", {31'd0, pe0}, 32'd0);
    chk("reset_overrun_err", {31'd0, ov0}, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_busy_par", {31'd0, busy1}, 32'd0);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end

    // 1: 0xA5 8N1
    vcyc0 = 0;
    q0.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
    chk("t1_valid_cycles", vcyc0, 32'd1);
    chk("t1_busy_after", {31'd0, busy0}, 32'd0);
    chk("t1_delivered", q0.size(), 32'd0);

    // 2: false start of 4 ticks
    hs_before = hs0;
    busy_cyc0 = 0;
    drive_bit(0, 1'b0, 40);
    drive_bit(0, 1'b1, 200);
    chk("t2_no_word", hs0, hs_before);
    chk("t2_busy_seen", {31'd0, busy_cyc0 > 60}, 32'd1);
    chk("t2_busy_max_8_ticks", {31'd0, busy_cyc0 <= 80}, 32'd1);
    chk("t2_back_in_idle", {31'd0, busy0}, 32'd0);

    // 3: 0x3C with stop bit 0
    hs_before = hs0;
    q0.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1);
    chk("t3_delivered", q0.size(), 32'd0);
    chk("t3_one_word", hs0, hs_before + 1);

    // 4: even parity, 0x07 with good then bad parity bit
    q1.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1);
    q1.push_back('{8'h07, 1'b0, 1'b1});
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1);
    chk("t4_delivered", q1.size(), 32'd0);

    // 5: overrun
    ready0 = 1'b0;
    q0.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1);
    chk("t5_valid_held", {31'd0, valid0}, 32'd1);
    chk("t5_old_word_kept", {24'd0, data0}, 32'h11);
    chk("t5_overrun_set", {31'd0, ov0}, 32'd1);
    ready0 = 1'b1;
    @(posedge clk);
    #1;
    ready0 = 1'b0;
    chk("t5_valid_cleared", {31'd0, valid0}, 32'd0);
    chk("t5_overrun_cleared", {31'd0, ov0}, 32'd0);
    chk("t5_delivered", q0.size(), 32'd0);
    ready0 = 1'b1;

    // 6: reset during data bit 3 of 0xFF, then 0x5A
    drive_bit(0, 1'b0, 160);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 160);
    drive_bit(0, 1'b1, 60);
    chk("t6_busy_mid_frame", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t6_rst_rx_data", {24'd0, data0}, 32'd0);
    chk("t6_rst_valid", {31'd0, valid0}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy0}, 32'd0);
    chk("t6_rst_overrun", {31'd0, ov0}, 32'd0);
    rst = 1'b0;
    hs_before = hs0;
    drive_bit(0, 1'b1, 160 * 6);
    chk("t6_aborted_no_word", hs0, hs_before);
    q0.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1);
    chk("t6_one_word", hs0, hs_before + 1);

    repeat (50) begin
      @(posedge clk);
      #1;
    end
    chk("end_q0_empty", q0.size(), 32'd0);
    chk("end_q1_empty", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
